// File: rtl/arf_seq_pkg.sv
// arf_seq_pkg: op codes, FSM states, ARF select codes and the per-phase control bundle
// shared by the ARF sequencer and its watchdog.
package arf_seq_pkg;
    localparam int TIMEOUT_DEF = 15;
    typedef enum logic [2:0] {
        OP_FETCH, OP_JUMP, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_CLR, OP_ILL
    } op_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_UPD, S_GAP, S_DONE} state_t;
    localparam logic [3:0] RS_NONE = 4'b0000;
    localparam logic [3:0] RS_PC   = 4'b1000;
    localparam logic [3:0] RS_AR   = 4'b0100;
    localparam logic [3:0] RS_SP   = 4'b0010;
    localparam logic [3:0] RS_PCP  = 4'b0001;
    localparam logic [3:0] RS_ALL  = RS_PC | RS_AR | RS_SP | RS_PCP;
    localparam logic [1:0] FN_CLR  = 2'b00;
    localparam logic [1:0] FN_LOAD = 2'b01;
    localparam logic [1:0] FN_DEC  = 2'b10;
    localparam logic [1:0] FN_INC  = 2'b11;
    localparam logic [1:0] SEL_AR  = 2'b00;
    localparam logic [1:0] SEL_SP  = 2'b01;
    localparam logic [1:0] SEL_PCP = 2'b10;
    localparam logic [1:0] SEL_PC  = 2'b11;
    typedef struct packed {
        logic [3:0] rsel;
        logic [1:0] funsel;
        logic [1:0] oasel;
        logic [1:0] obsel;
        logic       in_sel;
        logic       mem_req;
        logic       mem_we;
        logic       done;
        logic       err;
    } ctl_t;

    // Control outputs for the phase the sequencer is about to enter.
    function automatic ctl_t phase_ctl(op_t op, state_t st, logic second, logic err);
        ctl_t c = '{rsel: RS_NONE, funsel: FN_CLR, oasel: SEL_AR, obsel: SEL_AR, default: 1'b0};
        case (st)
            S_ADDR: begin
                c.oasel   = op == OP_FETCH ? SEL_PC : SEL_SP;
                c.mem_req = 1'b1;
                c.mem_we  = op == OP_PUSH;
            end
            S_UPD: case (op)
                OP_FETCH: begin c.rsel = RS_PC;  c.funsel = FN_INC; end
                OP_JUMP:  begin c.rsel = RS_PC;  c.funsel = FN_LOAD; end
                OP_PUSH:  begin c.rsel = RS_SP;  c.funsel = FN_DEC; end
                OP_POP:   begin c.rsel = RS_SP;  c.funsel = FN_INC; end
                OP_CALL:  begin
                    c.rsel   = second ? RS_PC : RS_PCP;
                    c.funsel = FN_LOAD;
                    c.obsel  = second ? SEL_AR : SEL_PC;
                    c.in_sel = !second;
                end
                OP_RET:   begin c.rsel = RS_PC; c.funsel = FN_LOAD; c.obsel = SEL_PCP; c.in_sel = 1'b1; end
                OP_CLR:   begin c.rsel = RS_ALL; c.funsel = FN_CLR; end
                default: ;
            endcase
            S_DONE: begin c.done = 1'b1; c.err = err; end
            default: ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/arf_sequencer_if.sv
// arf_seq_if: command handshake, ARF control and memory handshake bundle of the ARF sequencer.
interface arf_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_target;
    logic [3:0] arf_rsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_oasel;
    logic [1:0] arf_obsel;
    logic       arf_in_sel;
    logic [7:0] arf_target;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic       done;
    logic       err;
    modport master (
        output cmd_valid, cmd_op, cmd_target, mem_ack,
        input  cmd_ready, arf_rsel, arf_funsel, arf_oasel, arf_obsel, arf_in_sel, arf_target,
               mem_req, mem_we, done, err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_target, mem_ack,
        output cmd_ready, arf_rsel, arf_funsel, arf_oasel, arf_obsel, arf_in_sel, arf_target,
               mem_req, mem_we, done, err
    );
endinterface

// File: rtl/arf_seq_watchdog.sv
// arf_seq_watchdog: counts stalled memory-access cycles; expired marks the last allowed one.
module arf_seq_watchdog import arf_seq_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (start && !expired) count <= count + 1'b1;
    assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/arf_sequencer.sv
// arf_sequencer: turns FETCH/JUMP/PUSH/POP/CALL/RET/CLR commands into timed ARF
// write strobes and memory requests, with a watchdog on the memory handshake.
module arf_sequencer import arf_seq_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clock,
    input logic reset_n,
    arf_seq_if.slave bus
);
    state_t     state, state_nx;
    op_t        op, op_nx;
    logic       second, second_nx, err_nx, expired, accept;
    logic [7:0] target;
    ctl_t       ctl;

    assign accept = bus.cmd_valid && state == S_IDLE;
    assign op_nx  = accept ? op_t'(bus.cmd_op) : op;

    arf_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (state == S_ADDR && !bus.mem_ack),
        .clear   (state != S_ADDR),
        .expired (expired)
    );

    // second marks the PC write of CALL, the only op with two ARF writes.
    always_comb begin
        state_nx  = state;
        second_nx = second;
        err_nx    = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                state_nx  = op_nx inside {OP_FETCH, OP_POP} ? S_ADDR : op_nx == OP_ILL ? S_DONE : S_UPD;
                err_nx    = op_nx == OP_ILL;
                second_nx = 1'b0;
            end
            S_ADDR: if (bus.mem_ack) state_nx = op == OP_PUSH ? S_DONE : S_UPD;
                else if (expired) begin
                    state_nx = S_DONE;
                    err_nx   = 1'b1;
                end
            S_UPD: state_nx = op == OP_PUSH || (op == OP_CALL && !second) ? S_GAP : S_DONE;
            S_GAP: begin
                state_nx  = op == OP_PUSH ? S_ADDR : S_UPD;
                second_nx = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state  <= S_IDLE;
            op     <= OP_FETCH;
            second <= 1'b0;
            target <= '0;
            ctl    <= '0;
        end else begin
            state  <= state_nx;
            op     <= op_nx;
            second <= second_nx;
            ctl    <= phase_ctl(op_nx, state_nx, second_nx, err_nx);
            if (accept) target <= bus.cmd_target;
        end

    assign bus.cmd_ready  = state == S_IDLE;
    assign bus.arf_rsel   = ctl.rsel;
    assign bus.arf_funsel = ctl.funsel;
    assign bus.arf_oasel  = ctl.oasel;
    assign bus.arf_obsel  = ctl.obsel;
    assign bus.arf_in_sel = ctl.in_sel;
    assign bus.arf_target = target;
    assign bus.mem_req    = ctl.mem_req;
    assign bus.mem_we     = ctl.mem_we;
    assign bus.done       = ctl.done;
    assign bus.err        = ctl.err;
endmodule

// File: tb/tb_arf_sequencer.sv
// tb_arf_sequencer: random commands and memory-ack patterns checked cycle by cycle against
// a trace model built from the command rules, plus directed reset and literal checks.
module tb_arf_sequencer;
    localparam int TO = 15;
    typedef struct packed {
        logic       ready;
        logic [3:0] rsel;
        logic [1:0] fun;
        logic [1:0] oa;
        logic [1:0] ob;
        logic       insel;
        logic [7:0] tgt;
        logic       req;
        logic       we;
        logic       done;
        logic       err;
    } ov_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    arf_seq_if bus();
    arf_sequencer #(.TIMEOUT(TO)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));

    ov_t dut_v, exp_v;
    assign dut_v = {bus.cmd_ready, bus.arf_rsel, bus.arf_funsel, bus.arf_oasel, bus.arf_obsel,
                    bus.arf_in_sel, bus.arf_target, bus.mem_req, bus.mem_we, bus.done, bus.err};

    int vectors = 0;
    int miscompares = 0;
    bit chk = 0;
    ov_t exp_q[$];
    bit plan[64];
    logic [7:0] tgt_m = 8'h00;
    int pcts[4] = '{0, 30, 60, 100};

    always @(negedge clock) if (chk) begin
        vectors++;
        if (dut_v !== exp_v) begin
            miscompares++;
            $display("FAIL trace t=%0t got=%h exp=%h", $time, dut_v, exp_v);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", nm, act, expv);
        end
    endtask

    function automatic ov_t base();
        ov_t v = '0;
        v.tgt = tgt_m;
        return v;
    endfunction

    function automatic void wr(input logic [3:0] rs, input logic [1:0] fn, input logic [1:0] ob, input logic is);
        ov_t v = base();
        v.rsel = rs; v.fun = fn; v.ob = ob; v.insel = is;
        exp_q.push_back(v);
    endfunction

    function automatic void gap();
        exp_q.push_back(base());
    endfunction

    // Memory access: request held until ack is seen in a cycle, at most TO cycles.
    function automatic bit acc(input logic [1:0] oa, input logic we);
        for (int j = 0; j < TO; j++) begin
            ov_t v = base();
            v.oa = oa; v.req = 1'b1; v.we = we;
            exp_q.push_back(v);
            if (plan[exp_q.size()]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void build(input logic [2:0] op);
        bit e = 0;
        ov_t v;
        exp_q.delete();
        case (op)
            3'd0: begin e = !acc(2'b11, 1'b0); if (!e) wr(4'b1000, 2'b11, 2'b00, 1'b0); end
            3'd1: wr(4'b1000, 2'b01, 2'b00, 1'b0);
            3'd2: begin wr(4'b0010, 2'b10, 2'b00, 1'b0); gap(); e = !acc(2'b01, 1'b1); end
            3'd3: begin e = !acc(2'b01, 1'b0); if (!e) wr(4'b0010, 2'b11, 2'b00, 1'b0); end
            3'd4: begin wr(4'b0001, 2'b01, 2'b11, 1'b1); gap(); wr(4'b1000, 2'b01, 2'b00, 1'b0); end
            3'd5: wr(4'b1000, 2'b01, 2'b10, 1'b1);
            3'd6: wr(4'b1111, 2'b00, 2'b00, 1'b0);
            default: e = 1;
        endcase
        v = base();
        v.done = 1'b1; v.err = e;
        exp_q.push_back(v);
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] t, input int pct, input int ack_at);
        ov_t v;
        for (int i = 0; i < 64; i++) plan[i] = ack_at >= 0 ? (i == ack_at) : ($urandom_range(99) < pct);
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_target = t; bus.mem_ack = plan[0];
        v = base(); v.ready = 1'b1; exp_v = v; chk = 1;
        tgt_m = t;
        build(op);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(posedge clock); #1;
            bus.cmd_valid = 1'($urandom_range(1));
            bus.cmd_op = 3'($urandom_range(7));
            bus.cmd_target = 8'($urandom_range(255));
            bus.mem_ack = plan[c + 1];
            exp_v = exp_q[c];
        end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0; bus.mem_ack = 1'($urandom_range(1));
        v = base(); v.ready = 1'b1; exp_v = v;
    endtask

    initial begin
        ov_t v;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_target = 8'h00; bus.mem_ack = 1'b0;
        #12;
        v = base(); v.ready = 1'b1;
        lit("reset_idle", 32'(dut_v), 32'(v));
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        run_cmd(3'd1, 8'h3C, 0, -1);
        lit("jump_len", exp_q.size(), 2);
        lit("jump_rsel", exp_q[0].rsel, 4'b1000);
        lit("jump_fun", exp_q[0].fun, 2'b01);
        lit("jump_insel", exp_q[0].insel, 1'b0);
        lit("jump_tgt", exp_q[0].tgt, 8'h3C);
        lit("jump_done", {exp_q[1].done, exp_q[1].err}, 2'b10);

        run_cmd(3'd0, 8'h11, 0, 3);
        lit("fetch_len", exp_q.size(), 5);
        lit("fetch_addr", {exp_q[2].req, exp_q[2].we, exp_q[2].oa}, 4'b1011);
        lit("fetch_upd", {exp_q[3].req, exp_q[3].rsel, exp_q[3].fun}, 7'b0100011);
        lit("fetch_done", {exp_q[4].done, exp_q[4].err}, 2'b10);

        run_cmd(3'd4, 8'h80, 0, -1);
        lit("call_len", exp_q.size(), 4);
        lit("call_first", {exp_q[0].rsel, exp_q[0].ob, exp_q[0].insel}, 7'b0001111);
        lit("call_gap", exp_q[1].rsel, 4'b0000);
        lit("call_second", {exp_q[2].rsel, exp_q[2].insel}, 5'b10000);

        run_cmd(3'd3, 8'h42, 0, -1);
        lit("pop_to_len", exp_q.size(), TO + 1);
        lit("pop_to_req", exp_q[TO - 1].req, 1'b1);
        lit("pop_to_done", {exp_q[TO].req, exp_q[TO].rsel, exp_q[TO].done, exp_q[TO].err}, 7'b0000011);

        run_cmd(3'd7, 8'h99, 0, -1);
        lit("ill_len", exp_q.size(), 1);
        lit("ill_done", {exp_q[0].rsel, exp_q[0].req, exp_q[0].done, exp_q[0].err}, 7'b0000011);

        for (int k = 0; k < 150; k++)
            run_cmd(3'($urandom_range(7)), 8'($urandom_range(255)), pcts[$urandom_range(3)], -1);

        chk = 0;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_target = 8'h5A; bus.mem_ack = 1'b0;
        @(posedge clock); #1 bus.cmd_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        lit("push_addr_req", bus.mem_req, 1'b1);
        lit("push_addr_we", bus.mem_we, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        lit("rst_req", bus.mem_req, 1'b0);
        lit("rst_we", bus.mem_we, 1'b0);
        lit("rst_rsel", bus.arf_rsel, 4'b0000);
        lit("rst_tgt", bus.arf_target, 8'h00);
        @(posedge clock);
        @(posedge clock); #1 reset_n = 1'b1;
        tgt_m = 8'h00;
        repeat (4) begin
            @(negedge clock);
            lit("post_rst_ready", bus.cmd_ready, 1'b1);
            lit("post_rst_done", bus.done, 1'b0);
        end

        run_cmd(3'd6, 8'hA5, 0, -1);
        run_cmd(3'd5, 8'h0F, 0, -1);
        @(posedge clock); #1 chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/arf_sequencer.md
ARF_SEQUENCER -- requirements
Module: arf_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles waiting for mem_ack before abort.
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  sequencer idle, accepts command.
REQ-006 SHALL have port cmd_op  input  3  000 FETCH, 001 JUMP, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 CLR, 111 illegal.
REQ-007 SHALL have port cmd_target  input  8  jump/call destination.
REQ-008 SHALL have port arf_rsel  output  4  register write enables: bit3 PC, bit2 AR, bit1 SP, bit0 PCpast.
REQ-009 SHALL have port arf_funsel  output  2  00 clear, 01 load, 10 decrement, 11 increment.
REQ-010 SHALL have port arf_oasel / arf_obsel  output  2 each  00 AR, 01 SP, 10 PCpast, 11 PC.
REQ-011 SHALL have port arf_in_sel  output  1  ARF load source: 0 latched target, 1 ARF OutB loopback.
REQ-012 SHALL have port arf_target  output  8  latched cmd_target.
REQ-013 SHALL have ports mem_req, mem_we  output  1 each; mem_ack  input  1  memory handshake, address is ARF OutA.
REQ-014 SHALL have ports done, err  output  1 each  one-cycle completion pulse, error flag valid with done.

Function
REQ-015 States: IDLE, ADDR (memory access), UPD (one ARF write), GAP (rsel idle between writes), DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; accept on clock edge with cmd_valid and cmd_ready; cmd_op/cmd_target latched then.
REQ-017 arf_rsel SHALL be nonzero only in UPD, for exactly one cycle, 0000 in all other states; consecutive writes separated by GAP.
REQ-018 FETCH: ADDR oasel=11, mem_req=1, mem_we=0 until mem_ack; then UPD rsel=1000 funsel=11.
REQ-019 JUMP: UPD rsel=1000 funsel=01 in_sel=0; latency accept->done = 2 cycles.
REQ-020 PUSH: UPD rsel=0010 funsel=10; GAP; ADDR oasel=01 mem_req=1 mem_we=1 until mem_ack.
REQ-021 POP: ADDR oasel=01 read until mem_ack; UPD rsel=0010 funsel=11.
REQ-022 CALL: UPD rsel=0001 funsel=01 obsel=11 in_sel=1; GAP; UPD rsel=1000 funsel=01 in_sel=0.
REQ-023 RET: UPD rsel=1000 funsel=01 obsel=10 in_sel=1.
REQ-024 CLR: UPD rsel=1111 funsel=00.
REQ-025 Illegal op: no ARF write, no mem_req; DONE next cycle with err=1.
REQ-026 Watchdog: ADDR counts cycles; mem_ack absent for TIMEOUT cycles -> drop mem_req, skip pending UPD, DONE with err=1.
REQ-027 mem_ack outside ADDR SHALL be ignored; mem_ack in first ADDR cycle SHALL complete access (one-cycle ADDR).
REQ-028 DONE lasts one cycle with done=1, then IDLE; 8-bit values pass unmodified, no arithmetic in sequencer.
REQ-029 Idle output values: rsel=0000, funsel=00, oasel=00, obsel=00, in_sel=0, mem_req=0, mem_we=0, done=0, err=0.

Reset
REQ-030 reset_n low SHALL force IDLE and REQ-029 values immediately, independent of clock, including mid-command.
REQ-031 Reset SHALL clear latched op, target (00h) and watchdog count; cmd_ready=1 at first edge after release.

Structure
REQ-032 Package arf_seq_pkg SHALL hold op codes, state enum, RSel bit masks, FunSel and OASel/OBSel codes, default TIMEOUT.
REQ-033 Watchdog counter SHALL be sub-module arf_seq_watchdog (start, clear, expired); rest in arf_sequencer.

Verification
REQ-034 JUMP target 3Ch -> UPD cycle rsel=1000 funsel=01 in_sel=0 arf_target=3Ch; done 2 cycles after accept, err=0.
REQ-035 FETCH, mem_ack after 3 cycles -> mem_req high 3 cycles with oasel=11; then rsel=1000 funsel=11 one cycle; done.
REQ-036 CALL target 80h -> rsel=0001 obsel=11 in_sel=1, then one cycle rsel=0000, then rsel=1000 in_sel=0; done.
REQ-037 POP with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 cycles, no rsel write, done=1 err=1.
REQ-038 PUSH, reset_n low during ADDR -> mem_req, mem_we, rsel zero immediately; after release cmd_ready=1, no done pulse.
REQ-039 cmd_op=111 -> no rsel, no mem_req; done=1 err=1 one cycle after accept.
